// File: rtl/apple1_bus_pkg.sv
// apple1_bus_pkg: shared state encoding and default Apple-1 address map for the bus fabric.
package apple1_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } bus_state_t;

   localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

   localparam logic [15:0] RAM_BASE      = 16'h0000;
   localparam logic [15:0] RAM_MASK      = 16'hE000;
   localparam logic [15:0] WOZMON_BASE   = 16'hFF00;
   localparam logic [15:0] WOZMON_MASK   = 16'hFF00;
   localparam logic [15:0] BASIC_BASE    = 16'hE000;
   localparam logic [15:0] BASIC_MASK    = 16'hF000;
   localparam logic [15:0] RX_BASE       = 16'hD010;
   localparam logic [15:0] RX_MASK       = 16'hFFFE;
   localparam logic [15:0] TX_BASE       = 16'hD012;
   localparam logic [15:0] TX_MASK       = 16'hFFFE;
   localparam logic [15:0] VGA_MODE_BASE = 16'hC000;
   localparam logic [15:0] VGA_MODE_MASK = 16'hFFFC;

   // Slot 0 sits in the low bits; slot 5 is a spare that never decodes (mask 0).
   localparam logic [95:0] DEFAULT_SLOT_BASE =
      {16'h0000, TX_BASE, RX_BASE, BASIC_BASE, WOZMON_BASE, RAM_BASE};
   localparam logic [95:0] DEFAULT_SLOT_MASK =
      {16'h0000, TX_MASK, RX_MASK, BASIC_MASK, WOZMON_MASK, RAM_MASK};

endpackage

// File: rtl/apple1_bus_wait_fsm.sv
// apple1_bus_wait_fsm: stretches a CPU access by a per-slot number of cpu_clken strobes,
// aborting cleanly if the CPU moves its address mid-access.
module apple1_bus_wait_fsm
   import apple1_bus_pkg::*;
(
   input  logic        clk25,
   input  logic        rst,
   input  logic        cpu_clken,
   input  logic [15:0] ab,
   input  logic [3:0]  wait_cnt,
   output logic        ready
);

   bus_state_t  state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [15:0] lat_ab, lat_n;
   logic        abort;

   always_ff @(posedge clk25 or posedge rst)
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         lat_ab <= 16'h0000;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         lat_ab <= lat_n;
      end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lat_n   = lat_ab;
      ready   = 1'b0;
      abort   = state != IDLE && ab != lat_ab;
      case (state)
         IDLE: begin
            ready = wait_cnt == 4'd0;
            if (cpu_clken && wait_cnt != 4'd0) begin
               lat_n   = ab;
               cnt_n   = wait_cnt - 4'd1;
               state_n = wait_cnt == 4'd1 ? DONE : WAIT;
            end
         end
         WAIT:
            if (abort) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else if (cpu_clken) begin
               cnt_n   = cnt - 4'd1;
               state_n = cnt <= 4'd1 ? DONE : WAIT;
            end
         DONE: begin
            // An address change here must not complete the stale access.
            ready = !abort;
            if (abort || cpu_clken) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (rst) ready = 1'b1;
   end

endmodule

// File: rtl/apple1_bus_fabric.sv
// apple1_bus_fabric: 6502 bus decode, read mux, wait-state control and control register bank.
// Define APPLE1_BUS_ERR_EN to add sticky capture of unmapped accesses (bus_err/bus_err_addr).
module apple1_bus_fabric
   import apple1_bus_pkg::*;
#(
   parameter int                      NUM_SLOTS = 6,
   parameter logic [16*NUM_SLOTS-1:0] SLOT_BASE = DEFAULT_SLOT_BASE,
   parameter logic [16*NUM_SLOTS-1:0] SLOT_MASK = DEFAULT_SLOT_MASK,
   parameter logic [4*NUM_SLOTS-1:0]  SLOT_WAIT = '0,
   parameter logic [15:0]             REG_BASE  = VGA_MODE_BASE,
   parameter int                      NUM_REGS  = 4,
   parameter logic [8*NUM_REGS-1:0]   REG_INIT  = 32'h0000_0700,
   parameter logic [7:0]              OPEN_BUS  = OPEN_BUS_DEFAULT
) (
   input  logic                     clk25,
   input  logic                     rst,
   input  logic                     cpu_clken,
   input  logic [15:0]              ab,
   input  logic                     we,
   input  logic [7:0]               dbo,
   output logic [7:0]               dbi,
   output logic                     ready,
   output logic [NUM_SLOTS-1:0]     slot_cs,
   output logic [NUM_SLOTS-1:0]     slot_en,
   output logic [NUM_SLOTS-1:0]     slot_we,
   input  logic [8*NUM_SLOTS-1:0]   slot_dout,
   output logic [8*NUM_REGS-1:0]    regs
`ifdef APPLE1_BUS_ERR_EN
   ,
   output logic                     bus_err,
   output logic [15:0]              bus_err_addr,
   input  logic                     bus_err_clr
`endif
);

   localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
   localparam int RB = $clog2(NUM_REGS);
   localparam logic [NUM_SLOTS-1:0] ONE = 1;

   logic [NUM_SLOTS-1:0] hit;
   logic [SW-1:0]        sel;
   logic                 any;
   logic                 bank;
   logic [RB-1:0]        idx;
   logic [3:0]           wsel;
   logic                 go;

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
      assign hit[g] = (ab & SLOT_MASK[16*g+:16]) == SLOT_BASE[16*g+:16] && SLOT_MASK[16*g+:16] != 16'h0000;
   end

   // Descending scan so the lowest hitting index is the one left standing.
   always_comb begin
      sel = '0;
      any = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (hit[i]) begin
            sel = i[SW-1:0];
            any = 1'b1;
         end
   end

   assign bank    = !any && ab[15:RB] == REG_BASE[15:RB];
   assign idx     = ab[RB-1:0];
   assign wsel    = any ? SLOT_WAIT[{sel, 2'b00}+:4] : 4'd0;
   assign slot_cs = any ? ONE << sel : '0;
   assign go      = cpu_clken && ready && !rst;
   assign slot_en = slot_cs & {NUM_SLOTS{go}};
   assign slot_we = slot_en & {NUM_SLOTS{we}};
   assign dbi     = any ? slot_dout[{sel, 3'b000}+:8] : bank ? regs[{idx, 3'b000}+:8] : OPEN_BUS;

   apple1_bus_wait_fsm u_wait (
      .clk25     (clk25),
      .rst       (rst),
      .cpu_clken (cpu_clken),
      .ab        (ab),
      .wait_cnt  (wsel),
      .ready     (ready)
   );

   always_ff @(posedge clk25 or posedge rst)
      if (rst) regs <= REG_INIT;
      else if (go && we && bank) regs[{idx, 3'b000}+:8] <= dbo;

`ifdef APPLE1_BUS_ERR_EN
   // A fresh error beats a simultaneous clear so it is never lost.
   always_ff @(posedge clk25 or posedge rst)
      if (rst) begin
         bus_err      <= 1'b0;
         bus_err_addr <= 16'h0000;
      end else if (go && !any && !bank && (!bus_err || bus_err_clr)) begin
         bus_err      <= 1'b1;
         bus_err_addr <= ab;
      end else if (bus_err_clr) bus_err <= 1'b0;
`endif

endmodule

// File: tb/tb_apple1_bus_fabric.sv
// tb_apple1_bus_fabric: directed stimulus against an address-range/strobe-count model of the fabric.
// Define APPLE1_BUS_ERR_EN to also exercise bus error capture.
module tb_apple1_bus_fabric;

   logic        clk25 = 1'b0;
   logic        rst, cpu_clken, we;
   logic [15:0] ab;
   logic [7:0]  dbo, dbi;
   logic        ready;
   logic [5:0]  slot_cs, slot_en, slot_we;
   logic [47:0] slot_dout = 48'h5544_3322_11A5;
   logic [31:0] regs;
   logic        clr;
`ifdef APPLE1_BUS_ERR_EN
   logic        bus_err;
   logic [15:0] bus_err_addr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk25 = ~clk25;

   apple1_bus_fabric #(.SLOT_WAIT(24'h000300)) dut (
      .clk25        (clk25),
      .rst          (rst),
      .cpu_clken    (cpu_clken),
      .ab           (ab),
      .we           (we),
      .dbo          (dbo),
      .dbi          (dbi),
      .ready        (ready),
      .slot_cs      (slot_cs),
      .slot_en      (slot_en),
      .slot_we      (slot_we),
      .slot_dout    (slot_dout),
      .regs         (regs)
`ifdef APPLE1_BUS_ERR_EN
      ,
      .bus_err      (bus_err),
      .bus_err_addr (bus_err_addr),
      .bus_err_clr  (clr)
`endif
   );

   // Model: n = strobes already spent on the pending access to address pend.
   int          n = 0;
   logic [15:0] pend = 16'h0000;
   logic [7:0]  m_regs [4];
   logic        m_err = 1'b0;
   logic [15:0] m_err_addr = 16'h0000;

   function automatic int slot_of(input logic [15:0] a);
      if (a < 16'h2000) return 0;
      if (a >= 16'hFF00) return 1;
      if (a >= 16'hE000 && a < 16'hF000) return 2;
      if (a == 16'hD010 || a == 16'hD011) return 3;
      if (a == 16'hD012 || a == 16'hD013) return 4;
      return -1;
   endfunction

   function automatic bit in_bank(input logic [15:0] a);
      return slot_of(a) < 0 && a >= 16'hC000 && a <= 16'hC003;
   endfunction

   function automatic int wait_of(input logic [15:0] a);
      return slot_of(a) == 2 ? 3 : 0;
   endfunction

   function automatic bit exp_ready();
      if (rst) return 1'b1;
      if (n > 0 && ab != pend) return 1'b0;
      return n == wait_of(ab);
   endfunction

   function automatic logic [5:0] exp_cs();
      int s = slot_of(ab);
      return s < 0 ? 6'd0 : 6'd1 << s;
   endfunction

   function automatic logic [5:0] exp_en();
      return (!rst && cpu_clken && exp_ready()) ? exp_cs() : 6'd0;
   endfunction

   function automatic logic [7:0] exp_dbi();
      int s = slot_of(ab);
      if (s >= 0) return slot_dout[8*s+:8];
      return in_bank(ab) ? m_regs[ab[1:0]] : 8'hFF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk25 or posedge rst)
      if (rst) begin
         n = 0;
         m_regs = '{8'h00, 8'h07, 8'h00, 8'h00};
         m_err = 1'b0;
         m_err_addr = 16'h0000;
      end else begin
         if (cpu_clken && exp_ready() && slot_of(ab) < 0 && !in_bank(ab)) begin
            if (!m_err || clr) begin
               m_err = 1'b1;
               m_err_addr = ab;
            end
         end else if (clr) m_err = 1'b0;
         if (cpu_clken && exp_ready() && we && in_bank(ab)) m_regs[ab[1:0]] = dbo;
         if (n > 0 && ab != pend) n = 0;
         else if (cpu_clken) begin
            if (n == wait_of(ab)) n = 0;
            else begin
               n = n + 1;
               pend = ab;
            end
         end
      end

   always @(negedge clk25) begin
      chk("ready", {31'd0, ready}, {31'd0, exp_ready()});
      chk("slot_cs", {26'd0, slot_cs}, {26'd0, exp_cs()});
      chk("slot_en", {26'd0, slot_en}, {26'd0, exp_en()});
      chk("slot_we", {26'd0, slot_we}, {26'd0, exp_en() & {6{we}}});
      chk("dbi", {24'd0, dbi}, {24'd0, exp_dbi()});
      chk("regs", regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
`ifdef APPLE1_BUS_ERR_EN
      chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
      chk("bus_err_addr", {16'd0, bus_err_addr}, {16'd0, m_err_addr});
`endif
   end

   task automatic cyc(input logic [15:0] a, input logic c, input logic w, input logic [7:0] d);
      @(posedge clk25);
      #1;
      ab = a;
      cpu_clken = c;
      we = w;
      dbo = d;
      #1;
   endtask

   int strobes = 0, low = 0, pulses = 0, at = 0;

   initial begin
      rst = 1'b1; cpu_clken = 1'b1; we = 1'b0; ab = 16'hE000; dbo = 8'h00; clr = 1'b0;
      repeat (3) @(posedge clk25);
      #2;
      chk("lit_reset_regs", regs, 32'h0000_0700);
      chk("lit_reset_ready", {31'd0, ready}, 32'd1);
      chk("lit_reset_en", {26'd0, slot_en}, 32'd0);
      @(posedge clk25);
      #1; rst = 1'b0; ab = 16'hC001; cpu_clken = 1'b0;
      #1;
      chk("lit_reg1_read", {24'd0, dbi}, 32'h07);
      cyc(16'h1234, 1'b1, 1'b0, 8'h00);
      chk("lit_ram_cs", {26'd0, slot_cs}, 32'b000001);
      chk("lit_ram_dbi", {24'd0, dbi}, 32'hA5);
      chk("lit_ram_en", {26'd0, slot_en}, 32'b000001);
      cyc(16'hD011, 1'b0, 1'b0, 8'h00);
      chk("lit_rx_cs", {26'd0, slot_cs}, 32'b001000);
      cyc(16'hB000, 1'b1, 1'b0, 8'h00);
      chk("lit_open_cs", {26'd0, slot_cs}, 32'd0);
      chk("lit_open_dbi", {24'd0, dbi}, 32'hFF);
      cyc(16'hB001, 1'b1, 1'b0, 8'h00);
`ifdef APPLE1_BUS_ERR_EN
      cyc(16'h1234, 1'b0, 1'b0, 8'h00);
      chk("lit_err_set", {31'd0, bus_err}, 32'd1);
      chk("lit_err_first", {16'd0, bus_err_addr}, 32'hB000);
      clr = 1'b1;
      cyc(16'h1234, 1'b0, 1'b0, 8'h00);
      clr = 1'b0;
      chk("lit_err_clr", {31'd0, bus_err}, 32'd0);
      clr = 1'b1;
      cyc(16'hB002, 1'b1, 1'b0, 8'h00);
      cyc(16'h1234, 1'b0, 1'b0, 8'h00);
      clr = 1'b0;
      chk("lit_err_wins", {31'd0, bus_err}, 32'd1);
      chk("lit_err_addr2", {16'd0, bus_err_addr}, 32'hB002);
`endif
      cyc(16'h1234, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 20 && pulses == 0; c++) begin
         cyc(16'hE000, c[0], 1'b0, 8'h00);
         if (cpu_clken) begin
            strobes++;
            if (!ready) low++;
            if (slot_en[2]) begin
               pulses++;
               at = strobes;
            end
         end
      end
      chk("lit_wait_low", low, 32'd3);
      chk("lit_wait_pulses", pulses, 32'd1);
      chk("lit_wait_at", at, 32'd4);
      cyc(16'h1234, 1'b1, 1'b0, 8'h00);
      chk("lit_after_wait_en", {26'd0, slot_en}, 32'b000001);
      cyc(16'hE000, 1'b1, 1'b0, 8'h00);
      chk("lit_abort_idle_low", {31'd0, ready}, 32'd0);
      cyc(16'h0000, 1'b0, 1'b0, 8'h00);
      chk("lit_abort_pending", {31'd0, ready}, 32'd0);
      cyc(16'h0000, 1'b1, 1'b0, 8'h00);
      chk("lit_abort_ready", {31'd0, ready}, 32'd1);
      chk("lit_abort_ram_en", {26'd0, slot_en}, 32'b000001);
      cyc(16'hC002, 1'b1, 1'b1, 8'h03);
      chk("lit_regwr_no_slot", {26'd0, slot_en}, 32'd0);
      cyc(16'hC002, 1'b1, 1'b0, 8'h00);
      chk("lit_reg2_dbi", {24'd0, dbi}, 32'h03);
      chk("lit_reg2_regs", {24'd0, regs[23:16]}, 32'h03);
      cyc(16'hC002, 1'b0, 1'b1, 8'h5A);
      cyc(16'hC002, 1'b0, 1'b1, 8'h5A);
      cyc(16'hC000, 1'b1, 1'b0, 8'h00);
      chk("lit_reg_noclken", regs, 32'h0003_0700);
      cyc(16'hE000, 1'b1, 1'b0, 8'h00);
      cyc(16'hE000, 1'b1, 1'b0, 8'h00);
      chk("lit_midwait_low", {31'd0, ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("lit_midwait_rst_ready", {31'd0, ready}, 32'd1);
      chk("lit_midwait_rst_en", {26'd0, slot_en}, 32'd0);
      chk("lit_midwait_rst_regs", regs, 32'h0000_0700);
      cyc(16'hE000, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      cyc(16'h1234, 1'b1, 1'b0, 8'h00);
      chk("lit_post_rst_en", {26'd0, slot_en}, 32'b000001);
      cyc(16'h1234, 1'b0, 1'b0, 8'h00);
      @(posedge clk25);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
